// File: rtl/pe3_pass_ctrl.sv
// pe3_pass_ctrl: sequences read/write address pairs for one NTT pass through PE3.
// Optional feature macro PE3_PASS_STALL_EN adds a stall input that freezes the pass in place.
module pe3_pass_ctrl #(
   parameter int NUM_BF   = 256,
   parameter int ADDR_W   = 9,
   parameter int RD_LAT   = 1,
   parameter int PIPE_LAT = 6,
   parameter int LGS_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LGS_W-1:0]  lg_stride,
   input  logic              mode_ntt,
`ifdef PE3_PASS_STALL_EN
   input  logic              stall,
`endif
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_u,
   output logic [ADDR_W-1:0] rd_addr_v,
   output logic              pe_sel,
   output logic              pe_sel_ntt,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr_u,
   output logic [ADDR_W-1:0] wr_addr_v,
   output logic              busy,
   output logic              done
);

   localparam int              DLY    = RD_LAT + PIPE_LAT;
   localparam int              KW     = ADDR_W - 1;
   localparam logic [KW-1:0]   K_LAST = KW'(NUM_BF - 1);
   localparam logic [LGS_W-1:0] S_MAX = LGS_W'(ADDR_W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state_reg;
   logic [KW-1:0]     k_reg;
   logic [KW-1:0]     k_next;
   logic [LGS_W-1:0]  s_reg;
   logic [LGS_W-1:0]  s_clamp;
   logic [LGS_W-1:0]  s_sel;
   logic              rd_en_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              sel_ntt_reg;
   logic [ADDR_W-1:0] rd_u_reg;
   logic [ADDR_W-1:0] rd_v_reg;
   logic [ADDR_W-1:0] addr_u_next;
   logic [ADDR_W-1:0] addr_v_next;
   logic              dly_en_reg [DLY];
   logic [ADDR_W-1:0] dly_u_reg  [DLY];
   logic [ADDR_W-1:0] dly_v_reg  [DLY];
   logic              advance;
   logic              pending;

`ifdef PE3_PASS_STALL_EN
   assign advance = ~stall;
`else
   assign advance = 1'b1;
`endif

   // Strides beyond the address width fold onto the top address bit.
   assign s_clamp = (int'(lg_stride) > ADDR_W - 1) ? S_MAX : lg_stride;
   assign s_sel   = (state_reg == IDLE) ? s_clamp : s_reg;
   assign k_next  = (state_reg == IDLE) ? '0 : k_reg + KW'(1);

   // Insert a 0 (u) or 1 (v) at bit position s_sel of the butterfly index.
   for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_ins
      if (gi == 0) begin : g_lo
         assign addr_u_next[gi] = (s_sel == '0) ? 1'b0 : k_next[gi];
         assign addr_v_next[gi] = (s_sel == '0) ? 1'b1 : k_next[gi];
      end else if (gi == ADDR_W - 1) begin : g_hi
         assign addr_u_next[gi] = (int'(s_sel) == gi) ? 1'b0 : k_next[gi-1];
         assign addr_v_next[gi] = (int'(s_sel) == gi) ? 1'b1 : k_next[gi-1];
      end else begin : g_mid
         assign addr_u_next[gi] = (int'(s_sel) > gi)  ? k_next[gi] :
                                  (int'(s_sel) == gi) ? 1'b0 : k_next[gi-1];
         assign addr_v_next[gi] = (int'(s_sel) > gi)  ? k_next[gi] :
                                  (int'(s_sel) == gi) ? 1'b1 : k_next[gi-1];
      end
   end

   // Reads still travelling through RAM + PE3; the last one leaves via stage DLY-1.
   always_comb begin
      pending = rd_en_reg;
      for (int i = 0; i < DLY - 1; i++) begin
         pending = pending | dly_en_reg[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         k_reg       <= '0;
         s_reg       <= '0;
         rd_en_reg   <= 1'b0;
         rd_u_reg    <= '0;
         rd_v_reg    <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         sel_ntt_reg <= 1'b0;
      end else if (advance) begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg   <= RUN;
                  s_reg       <= s_clamp;
                  sel_ntt_reg <= mode_ntt;
                  k_reg       <= k_next;
                  rd_en_reg   <= 1'b1;
                  rd_u_reg    <= addr_u_next;
                  rd_v_reg    <= addr_v_next;
                  busy_reg    <= 1'b1;
               end
            end
            RUN: begin
               if (k_reg == K_LAST) begin
                  rd_en_reg <= 1'b0;
                  state_reg <= DRAIN;
               end else begin
                  k_reg    <= k_next;
                  rd_u_reg <= addr_u_next;
                  rd_v_reg <= addr_v_next;
               end
            end
            DRAIN: begin
               if (!pending) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Write delay line: clearing it on reset drops any reads that were in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DLY; i++) begin
            dly_en_reg[i] <= 1'b0;
            dly_u_reg[i]  <= '0;
            dly_v_reg[i]  <= '0;
         end
      end else if (advance) begin
         dly_en_reg[0] <= rd_en_reg;
         dly_u_reg[0]  <= rd_u_reg;
         dly_v_reg[0]  <= rd_v_reg;
         for (int i = 1; i < DLY; i++) begin
            dly_en_reg[i] <= dly_en_reg[i-1];
            dly_u_reg[i]  <= dly_u_reg[i-1];
            dly_v_reg[i]  <= dly_v_reg[i-1];
         end
      end
   end

   assign rd_en      = rd_en_reg & advance;
   assign rd_addr_u  = rd_u_reg;
   assign rd_addr_v  = rd_v_reg;
   assign wr_en      = dly_en_reg[DLY-1] & advance;
   assign wr_addr_u  = dly_u_reg[DLY-1];
   assign wr_addr_v  = dly_v_reg[DLY-1];
   assign busy       = busy_reg;
   assign pe_sel     = busy_reg;
   assign pe_sel_ntt = sel_ntt_reg;
   assign done       = done_reg & advance;

endmodule

// File: tb/tb_pe3_pass_ctrl.sv
// Directed/randomized bench for pe3_pass_ctrl against a cycle-level timing and address model.
module tb_pe3_pass_ctrl;
   localparam int NUM_BF = 256;
   localparam int ADDR_W = 9;
   localparam int LAT    = 7;
   localparam int C_DONE = NUM_BF + LAT + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [3:0]        lg_stride;
   logic              mode_ntt;
`ifdef PE3_PASS_STALL_EN
   logic              stall = 1'b0;
`endif
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr_u;
   logic [ADDR_W-1:0] rd_addr_v;
   logic              pe_sel;
   logic              pe_sel_ntt;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr_u;
   logic [ADDR_W-1:0] wr_addr_v;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_pass   = 0;
   int cur_cyc  = 0;

   always #5 clk = ~clk;

   pe3_pass_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .lg_stride(lg_stride), .mode_ntt(mode_ntt),
`ifdef PE3_PASS_STALL_EN
      .stall(stall),
`endif
      .rd_en(rd_en), .rd_addr_u(rd_addr_u), .rd_addr_v(rd_addr_v),
      .pe_sel(pe_sel), .pe_sel_ntt(pe_sel_ntt),
      .wr_en(wr_en), .wr_addr_u(wr_addr_u), .wr_addr_v(wr_addr_v),
      .busy(busy), .done(done)
   );

   // Butterfly k with span 2^s: block k/span, offset k%span, v is u + span.
   function automatic int model_addr(int k, int s, int odd);
      int se;
      int span;
      se   = (s > ADDR_W - 1) ? ADDR_W - 1 : s;
      span = 1 << se;
      return (k / span) * (2 * span) + odd * span + (k % span);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cur_cyc, obs, exp);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".rd_en"},      32'(rd_en),      32'd0);
      chk({tag, ".rd_addr_u"},  32'(rd_addr_u),  32'd0);
      chk({tag, ".rd_addr_v"},  32'(rd_addr_v),  32'd0);
      chk({tag, ".wr_en"},      32'(wr_en),      32'd0);
      chk({tag, ".wr_addr_u"},  32'(wr_addr_u),  32'd0);
      chk({tag, ".wr_addr_v"},  32'(wr_addr_v),  32'd0);
      chk({tag, ".busy"},       32'(busy),       32'd0);
      chk({tag, ".pe_sel"},     32'(pe_sel),     32'd0);
      chk({tag, ".pe_sel_ntt"}, 32'(pe_sel_ntt), 32'd0);
      chk({tag, ".done"},       32'(done),       32'd0);
   endtask

   // Caller is #1 after a posedge; start is taken on the next edge (cycle 0).
   task automatic run_pass(input int s, input bit m, input int n_pulses, input int abort_at);
      int  pulse_c[$];
      int  n_rd;
      int  n_wr;
      int  n_done;
      bit  exp_rd, exp_wr, exp_busy, exp_done, do_pulse;
      n_rd = 0; n_wr = 0; n_done = 0;
      if (n_pulses > 0) begin
         pulse_c.push_back(5);
         pulse_c.push_back(100);
         for (int i = 2; i < n_pulses; i++) pulse_c.push_back(int'($urandom_range(2, C_DONE - 2)));
      end
      lg_stride = 4'(s);
      mode_ntt  = m;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      lg_stride = 4'($urandom);
      mode_ntt  = 1'($urandom);
      for (int c = 1; c <= C_DONE + 1; c++) begin
         cur_cyc  = c;
         exp_rd   = (c <= NUM_BF);
         exp_wr   = (c >= 1 + LAT) && (c <= NUM_BF + LAT);
         exp_busy = (c <= C_DONE);
         exp_done = (c == C_DONE);
         chk("rd_en", 32'(rd_en), 32'(exp_rd));
         if (exp_rd) begin
            chk("rd_addr_u", 32'(rd_addr_u), 32'(model_addr(c - 1, s, 0)));
            chk("rd_addr_v", 32'(rd_addr_v), 32'(model_addr(c - 1, s, 1)));
         end
         chk("wr_en", 32'(wr_en), 32'(exp_wr));
         if (exp_wr) begin
            chk("wr_addr_u", 32'(wr_addr_u), 32'(model_addr(c - 1 - LAT, s, 0)));
            chk("wr_addr_v", 32'(wr_addr_v), 32'(model_addr(c - 1 - LAT, s, 1)));
         end
         chk("busy",       32'(busy),       32'(exp_busy));
         chk("pe_sel",     32'(pe_sel),     32'(exp_busy));
         chk("done",       32'(done),       32'(exp_done));
         chk("pe_sel_ntt", 32'(pe_sel_ntt), 32'(m));
         if (rd_en === 1'b1) n_rd++;
         if (wr_en === 1'b1) n_wr++;
         if (done === 1'b1) n_done++;
         if (c == abort_at) begin
            #1; rst = 1'b0; #1;
            check_all_zero("rst_async");
            for (int i = 0; i < 3; i++) begin
               @(posedge clk); #1;
               check_all_zero("rst_hold");
            end
            rst = 1'b1;
            for (int i = 0; i < 10; i++) begin
               @(posedge clk); #1;
               cur_cyc = c + 4 + i;
               check_all_zero("rst_after");
            end
            return;
         end
         do_pulse = 1'b0;
         foreach (pulse_c[j]) if (pulse_c[j] == c) do_pulse = 1'b1;
         start = do_pulse;
         if (c <= C_DONE) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      chk("n_reads",  32'(n_rd),   32'(NUM_BF));
      chk("n_writes", 32'(n_wr),   32'(NUM_BF));
      chk("n_done",   32'(n_done), 32'd1);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      lg_stride = '0;
      mode_ntt  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("idle");

      run_pass(0, 1'b1, 0, 0);
      run_pass(8, 1'b0, 4, 0);
      run_pass(int'($urandom_range(0, 15)), 1'b1, 3, 50);
      run_pass(int'($urandom_range(0, 15)), 1'($urandom), 0, 0);
      run_pass(12, 1'b1, 0, 0);
      for (int p = 0; p < 2; p++) begin
         run_pass(int'($urandom_range(0, 15)), 1'($urandom), 2 + int'($urandom_range(0, 3)), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
